// File: rtl/avr_wdc.sv
// AVR width down-converter: splits each wide IW-bit word into up to RATIO
// narrow OW-bit beats, LSB slice first, and marks the final beat with s_last.
module avr_wdc #(
    parameter int IW    = 256,
    parameter int RATIO = 4,
    localparam int OW   = IW / RATIO,
    localparam int CW   = $clog2(RATIO)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] m_data,
    input  logic [CW-1:0] m_cnt,
    input  logic          m_valid,
    output logic          m_ready,
    output logic [OW-1:0] s_data,
    output logic          s_last,
    output logic          s_valid,
    input  logic          s_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [RATIO-1:0][OW-1:0] hold_q, hold_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [CW-1:0]            idx_q, idx_d;

    logic full;
    logic m_fire;
    logic s_fire;
    logic last_fire;

    // Outputs come from registers only; s_ready -> m_ready is the one
    // combinational path, so a new word loads in the same cycle the last beat leaves.
    assign full      = (state_q == BUSY);
    assign s_valid   = full;
    assign s_data    = hold_q[idx_q];
    assign s_last    = full & (idx_q == cnt_q);
    assign s_fire    = s_valid & s_ready;
    assign last_fire = s_fire & s_last;
    assign m_ready   = ~full | last_fire;
    assign m_fire    = m_valid & m_ready;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;

        unique case (state_q)
            EMPTY: begin
                if (m_fire) begin
                    hold_d  = m_data;
                    cnt_d   = m_cnt;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last_fire) begin
                    idx_d = '0;
                    if (m_fire) begin
                        hold_d = m_data;
                        cnt_d  = m_cnt;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (s_fire) begin
                    idx_d = idx_q + CW'(1);
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: the holding register is a plain flop bank, not a memory, so it is
    // reset with the rest of the state; s_data then reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            hold_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            // NOTE: non-blocking so all flops update from pre-edge values.
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_avr_wdc.sv
// Self-checking bench for avr_wdc: directed scenarios plus random traffic,
// scored by a beat queue filled on word acceptance and drained by a monitor.
module tb_avr_wdc;

    localparam int IW    = 32;
    localparam int RATIO = 4;
    localparam int OW    = 8;
    localparam int CW    = 2;

    logic          clk;
    logic          rst_n;
    logic [IW-1:0] m_data;
    logic [CW-1:0] m_cnt;
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] s_data;
    logic          s_last;
    logic          s_valid;
    logic          s_ready;

    avr_wdc #(.IW(IW), .RATIO(RATIO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_data  (m_data),
        .m_cnt   (m_cnt),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_valid (s_valid),
        .s_ready (s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    beats_out   = 0;
    int    words_in    = 0;
    logic  rnd_done    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word of cnt+1 slices becomes cnt+1 beats, LSB first,
    // with only the final one flagged last.
    task automatic push_word(input logic [IW-1:0] w, input logic [CW-1:0] c);
        beat_t b;
        for (int k = 0; k <= int'(c); k++) begin
            b.data = w[k*OW +: OW];
            b.last = (k == int'(c));
            exp_q.push_back(b);
        end
        words_in++;
    endtask

    // Offer one word; once accepted its beats enter the expectation queue.
    task automatic send_word(input logic [IW-1:0] w, input logic [CW-1:0] c);
        logic fire;
        int   n;
        m_data  = w;
        m_cnt   = c;
        m_valid = 1'b1;
        fire    = 1'b0;
        n       = 0;
        while (!fire && n < 200) begin
            @(negedge clk);
            fire = m_ready & rst_n;
            @(posedge clk);
            #1;
            n++;
        end
        m_valid = 1'b0;
        if (fire) push_word(w, c);
        else check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        m_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    // Monitor: every cycle compares the outputs against the model queue,
    // which holds exactly the beats still owed by the DUT.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                exp_q.delete();
                check("rst_s_valid", s_valid, 32'd0);
                check("rst_m_ready", m_ready, 32'd1);
            end else begin
                check("s_valid", s_valid, (exp_q.size() != 0));
                check("m_ready", m_ready,
                      (exp_q.size() == 0) || (exp_q.size() == 1 && s_ready));
                if (exp_q.size() != 0) begin
                    check("s_data", s_data, exp_q[0].data);
                    check("s_last", s_last, exp_q[0].last);
                    if (s_valid && s_ready) begin
                        void'(exp_q.pop_front());
                        beats_out++;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0;
        int w0;
        rst_n   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_cnt   = '0;
        s_ready = 1'b1;
        #2;
        check("reset_s_valid", s_valid, 32'd0);
        check("reset_s_last",  s_last,  32'd0);
        check("reset_s_data",  s_data,  32'd0);
        check("reset_m_ready", m_ready, 32'd1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single full word
        b0 = beats_out;
        send_word(32'hDDCCBBAA, 2'd3);
        wait_drain();
        check("t1_beats", beats_out - b0, 32'd4);

        // 2: back-to-back words, no bubble
        b0 = beats_out;
        send_word(32'h44332211, 2'd3);
        send_word(32'h88776655, 2'd1);
        wait_drain();
        check("t2_beats", beats_out - b0, 32'd6);

        // 3: one-slice words at full rate
        b0 = beats_out;
        for (int i = 0; i < 4; i++)
            send_word({8'hF3, 8'hF2, 8'hF1, 8'(8'hA0 + i)}, 2'd0);
        wait_drain();
        check("t3_beats", beats_out - b0, 32'd4);

        // 4: backpressure pattern 1,0,0,1,0,1,1
        begin
            logic [6:0] pat;
            pat = 7'b1101001;
            b0  = beats_out;
            send_word(32'hDDCCBBAA, 2'd3);
            for (int i = 0; i < 7; i++) begin
                s_ready = pat[i];
                @(posedge clk);
                #1;
            end
            s_ready = 1'b1;
            check("t4_beats", beats_out - b0, 32'd4);
            check("t4_empty", exp_q.size(), 32'd0);
        end

        // 5: reset after BB is accepted
        b0 = beats_out;
        send_word(32'hDDCCBBAA, 2'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_beats_before", beats_out - b0, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_s_valid", s_valid, 32'd0);
        check("t5_m_ready", m_ready, 32'd1);
        @(negedge clk);
        #3;
        check("t5_flush", exp_q.size(), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        b0 = beats_out;
        send_word(32'h04030201, 2'd3);
        wait_drain();
        check("t5_beats_after", beats_out - b0, 32'd4);

        // 6: idle upstream, then confirm the next word starts at slice 0
        idle(5);
        check("t6_s_valid", s_valid, 32'd0);
        check("t6_m_ready", m_ready, 32'd1);
        b0 = beats_out;
        send_word(32'h5A6B7C8D, 2'd2);
        wait_drain();
        check("t6_beats", beats_out - b0, 32'd3);

        // Random traffic with random backpressure
        w0 = words_in;
        b0 = beats_out;
        begin
            int exp_beats;
            exp_beats = 0;
            fork
                begin
                    for (int i = 0; i < 150; i++) begin
                        logic [IW-1:0] w;
                        logic [CW-1:0] c;
                        w = $urandom;
                        c = CW'($urandom_range(0, RATIO - 1));
                        exp_beats += int'(c) + 1;
                        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                        send_word(w, c);
                    end
                    wait_drain();
                    rnd_done = 1'b1;
                end
                begin
                    while (!rnd_done) begin
                        s_ready = ($urandom_range(0, 3) != 0);
                        @(posedge clk);
                        #1;
                    end
                    s_ready = 1'b1;
                end
            join
            check("rnd_words", words_in - w0, 32'd150);
            check("rnd_beats", beats_out - b0, exp_beats);
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
